// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

  localparam int unsigned CREDIT_W         = 3;
  localparam int unsigned CREDIT_MAX       = 7;
  localparam int unsigned PRICE_DEF        = 3;
  localparam int unsigned DISP_TIMEOUT_DEF = 8;
  localparam int unsigned SUM_W            = CREDIT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_t;

  // Credit addition clamped at CREDIT_MAX.
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(CREDIT_MAX)) return CREDIT_W'(CREDIT_MAX);
    return s[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge strobe.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic i_async,
  output logic o_strobe
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [2:0] r_fill;

  // Sync chain; strobes are suppressed until r_prev holds real post-reset data,
  // so an input held high through reset never produces an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_prev   <= 1'b0;
      r_fill   <= 3'b000;
      o_strobe <= 1'b0;
    end else if (ena) begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_fill   <= {r_fill[1:0], 1'b1};
      o_strobe <= r_sync & ~r_prev & r_fill[2];
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: credit, dispense handshake, refund.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE        = PRICE_DEF,
  parameter int unsigned DISP_TIMEOUT = DISP_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                coin_in,
  input  logic                sel_in,
  input  logic                cancel_in,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] prod_cnt,
  output logic                refund,
  output logic                deny,
  output logic                fault,
  output logic [1:0]          state_o
);

  localparam int unsigned TMO_W = $clog2(DISP_TIMEOUT + 1);

  logic w_coin_stb;
  logic w_sel_stb;
  logic w_cancel_stb;

  state_t              r_state,  w_state_n;
  logic [CREDIT_W-1:0] r_credit, w_credit_n;
  logic [CREDIT_W-1:0] r_prod,   w_prod_n;
  logic [TMO_W-1:0]    r_tmo,    w_tmo_n;
  logic                r_dreq,   w_dreq_n;
  logic                r_refund, w_refund_n;
  logic                r_deny,   w_deny_n;
  logic                r_fault,  w_fault_n;

  logic [CREDIT_W-1:0] w_cred_coin;
  logic                w_coin_full;

  edge_sync u_coin   (.clk(clk), .rst_n(rst_n), .ena(ena), .i_async(coin_in),   .o_strobe(w_coin_stb));
  edge_sync u_sel    (.clk(clk), .rst_n(rst_n), .ena(ena), .i_async(sel_in),    .o_strobe(w_sel_stb));
  edge_sync u_cancel (.clk(clk), .rst_n(rst_n), .ena(ena), .i_async(cancel_in), .o_strobe(w_cancel_stb));

  // Credit after this cycle's coin (if any); a coin at full credit is rejected.
  assign w_cred_coin = w_coin_stb ? sat_add(r_credit, CREDIT_W'(1)) : r_credit;
  assign w_coin_full = w_coin_stb && (r_credit == CREDIT_W'(CREDIT_MAX));

  // State and output registers; ena low freezes everything and clears pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_prod   <= '0;
      r_tmo    <= '0;
      r_dreq   <= 1'b0;
      r_refund <= 1'b0;
      r_deny   <= 1'b0;
      r_fault  <= 1'b0;
    end else if (ena) begin
      r_state  <= w_state_n;
      r_credit <= w_credit_n;
      r_prod   <= w_prod_n;
      r_tmo    <= w_tmo_n;
      r_dreq   <= w_dreq_n;
      r_refund <= w_refund_n;
      r_deny   <= w_deny_n;
      r_fault  <= w_fault_n;
    end else begin
      r_refund <= 1'b0;
      r_deny   <= 1'b0;
      r_fault  <= 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n  = r_state;
    w_credit_n = r_credit;
    w_prod_n   = r_prod;
    w_tmo_n    = r_tmo;
    w_dreq_n   = r_dreq;
    w_refund_n = 1'b0;
    w_deny_n   = 1'b0;
    w_fault_n  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_credit_n = '0;
        if (w_coin_stb) begin
          w_credit_n = CREDIT_W'(1);
          w_state_n  = ST_COLLECT;
        end
        if (w_sel_stb) w_deny_n = 1'b1;
      end
      ST_COLLECT: begin
        w_credit_n = w_cred_coin;
        w_deny_n   = w_coin_full;
        if (w_cancel_stb) begin
          w_state_n = ST_REFUND;
        end else if (w_sel_stb) begin
          // A coin landing in the same cycle as select counts toward the price.
          if (w_cred_coin >= CREDIT_W'(PRICE)) begin
            w_credit_n = w_cred_coin - CREDIT_W'(PRICE);
            w_state_n  = ST_DISPENSE;
            w_dreq_n   = 1'b1;
            w_tmo_n    = '0;
          end else begin
            w_deny_n = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        w_credit_n = w_cred_coin;
        w_deny_n   = w_coin_full;
        if (disp_ack) begin
          w_dreq_n  = 1'b0;
          w_prod_n  = r_prod + CREDIT_W'(1);
          w_state_n = (w_cred_coin != '0) ? ST_COLLECT : ST_IDLE;
        end else if (r_tmo == TMO_W'(DISP_TIMEOUT - 1)) begin
          // Dispenser never answered: give the price back as credit.
          w_fault_n  = 1'b1;
          w_dreq_n   = 1'b0;
          w_credit_n = sat_add(w_cred_coin, CREDIT_W'(PRICE));
          w_state_n  = ST_COLLECT;
        end else begin
          w_tmo_n = r_tmo + TMO_W'(1);
        end
      end
      ST_REFUND: begin
        if (w_coin_stb) w_deny_n = 1'b1;
        if (r_credit != '0) begin
          w_refund_n = 1'b1;
          w_credit_n = r_credit - CREDIT_W'(1);
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign disp_req = r_dreq;
  assign credit   = r_credit;
  assign prod_cnt = r_prod;
  assign refund   = r_refund;
  assign deny     = r_deny;
  assign fault    = r_fault;
  assign state_o  = r_state;

endmodule
